game_ctrl_mc: RTL and testbench
===============================

// Module: game_ctrl_mc
// PURPOSE
//  Multi-channel game controller for the plane-war VGA pipeline. Detects per-pixel
//  collisions between player, bullets and N enemy channels; accumulates them per frame.
//  Runs the game FSM with lives, respawn invulnerability, pause and score.
//  Sits between the sprite alpha generators and the display/scoreboard logic.
// PARAMETERS
//  N_ENEMY      4   enemy sprite channels (1..16)
//  LIVES        3   lives granted at game start (1..7)
//  INVULN_FRM   60  frames of invulnerability after a life is lost (>=1)
//  SCORE_W      16  score counter width
// PORTS
//  clk_vga              in   1          pixel clock
//  rst                  in   1          async reset, active-high
//  frame_i              in   1          1-cycle pulse, first cycle of vertical blank
//  disp_i               in   1          pixel inside active area
//  me_alpha_i           in   1          player sprite opaque at current pixel
//  bullet_alpha_i       in   1          any bullet opaque at current pixel
//  enemy_alpha_i        in   N_ENEMY    per-channel enemy opaque at current pixel
//  gamestart_i          in   1          start/restart request (level)
//  pause_i              in   1          pause toggle request (rising edge acts)
//  game_status_o        out  `GAME_STATUS_BIT_LEN  FSM state
//  crash_me_enemy_o     out  1          raw player/enemy overlap, this pixel
//  crash_enemy_bullet_o out  N_ENEMY    raw bullet/enemy overlap, this pixel, per channel
//  bomb_o               out  N_ENEMY    1-cycle pulse at frame_i: channel i destroyed
//  lives_o              out  3          remaining lives
//  score_o              out  SCORE_W    current score
//  hiscore_o            out  SCORE_W    best score (see CONFIGURATION)
// BEHAVIOUR
//  States: PAUSE=000 RUN=001 PRERUN=010 OVER=011 RESPAWN=101. Reset: PRERUN, lives_o=LIVES,
//   score_o=0, hiscore_o=0, bomb_o=0; crash outputs combinational, forced 0 while rst.
//  Raw crash: crash_me_enemy_o = me_alpha_i & |enemy_alpha_i & disp_i;
//   crash_enemy_bullet_o[i] = enemy_alpha_i[i] & bullet_alpha_i & disp_i. Zero latency.
//  Sticky flags: hit_me and kill[i] set on raw crash only in RUN (hit_me: RUN only; kill[i]:
//   RUN and RESPAWN); all cleared on the frame_i cycle after being sampled.
//  Frame update (on frame_i, registered, visible next cycle):
//   bomb_o = kill; score += popcount(kill), saturating at 2^SCORE_W-1.
//   RUN & hit_me: lives-1; lives==1 before decrement -> OVER, else -> RESPAWN, inv_cnt=INVULN_FRM.
//   RESPAWN: inv_cnt-1 per frame; reaching 0 -> RUN. Player crashes ignored in RESPAWN.
//  Transitions (non-frame, evaluated every cycle, frame update has priority same cycle):
//   PRERUN & gamestart_i -> RUN, lives=LIVES, score=0.
//   OVER & gamestart_i -> PRERUN (needs gamestart_i low for >=1 cycle since entering OVER).
//   RUN/RESPAWN & pause rising edge -> PAUSE (remember source, inv_cnt frozen);
//   PAUSE & pause rising edge -> back to remembered state. No flag set or score change in PAUSE.
//  bomb_o high exactly one cycle; zero outside frame cycle. Reset mid-frame discards flags.
//  Simultaneous hit_me and kills in same frame: both score and life loss apply.
// CONFIGURATION
//  GAME_CTRL_HISCORE_EN defined: hiscore_o register updated to score_o when entering OVER if
//   score_o > hiscore_o; survives restart, cleared only by rst.
//  Undefined: hiscore_o tied to 0, no register inferred.
// TESTING
//  T1 rst, gamestart_i=1 -> status 010->001, lives_o=3, score_o=0.
//  T2 RUN, enemy_alpha_i=4'b0101 & bullet & disp one pixel, frame_i -> bomb_o=0101 1 cycle, score 2.
//  T3 RUN, me/enemy overlap, frame_i -> lives 2, status 101; after 60 frames -> 001.
//  T4 overlap in RESPAWN -> lives unchanged; three hits in RUN -> status 011, lives 0.
//  T5 pause edge in RESPAWN, 10 frames, pause edge -> back to 101, inv_cnt unchanged by pause.
//  T6 SCORE_W=4, 20 kills -> score_o=15; HISCORE_EN: game over -> hiscore_o=15, restart keeps it.

Source files
------------

// File: rtl/game_ctrl_mc_if.sv
// Controller bus for game_ctrl_mc: sprite alpha inputs, game controls, crash/score outputs.
`ifndef GAME_STATUS_BIT_LEN
`define GAME_STATUS_BIT_LEN 3
`endif

interface game_ctrl_mc_if #(
  parameter int unsigned N_ENEMY = 4,
  parameter int unsigned SCORE_W = 16
);
  logic                            frame_i;
  logic                            disp_i;
  logic                            me_alpha_i;
  logic                            bullet_alpha_i;
  logic [N_ENEMY-1:0]              enemy_alpha_i;
  logic                            gamestart_i;
  logic                            pause_i;
  logic [`GAME_STATUS_BIT_LEN-1:0] game_status_o;
  logic                            crash_me_enemy_o;
  logic [N_ENEMY-1:0]              crash_enemy_bullet_o;
  logic [N_ENEMY-1:0]              bomb_o;
  logic [2:0]                      lives_o;
  logic [SCORE_W-1:0]              score_o;
  logic [SCORE_W-1:0]              hiscore_o;

  modport master (
    output frame_i, disp_i, me_alpha_i, bullet_alpha_i, enemy_alpha_i, gamestart_i, pause_i,
    input  game_status_o, crash_me_enemy_o, crash_enemy_bullet_o, bomb_o, lives_o, score_o,
           hiscore_o
  );

  modport slave (
    input  frame_i, disp_i, me_alpha_i, bullet_alpha_i, enemy_alpha_i, gamestart_i, pause_i,
    output game_status_o, crash_me_enemy_o, crash_enemy_bullet_o, bomb_o, lives_o, score_o,
           hiscore_o
  );
endinterface

// File: rtl/game_ctrl_mc.sv
// Plane-war game controller: per-pixel collision detect, per-frame kill/hit accounting, game FSM.
// Optional high-score register enabled by defining GAME_CTRL_HISCORE_EN.
module game_ctrl_mc #(
  parameter int unsigned N_ENEMY    = 4,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned INVULN_FRM = 60,
  parameter int unsigned SCORE_W    = 16
) (
  input logic           clk_vga,
  input logic           rst,
  game_ctrl_mc_if.slave bus
);
  localparam int unsigned INV_W = $clog2(INVULN_FRM + 1);
  localparam int unsigned POP_W = $clog2(N_ENEMY + 1);
  localparam int unsigned SUM_W = SCORE_W + POP_W;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    ST_PAUSE   = 3'b000,
    ST_RUN     = 3'b001,
    ST_PRERUN  = 3'b010,
    ST_OVER    = 3'b011,
    ST_RESPAWN = 3'b101
  } state_t;

  state_t             state;
  state_t             resume;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [N_ENEMY-1:0] kill;
  logic [N_ENEMY-1:0] bomb;
  logic               hit_me;
  logic               pause_q;
  logic               over_armed;
  logic [INV_W-1:0]   inv_cnt;

  logic               crash_me;
  logic [N_ENEMY-1:0] crash_eb;
  logic               pause_rise;
  logic               active;
  logic [POP_W-1:0]   kill_cnt;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_nx;

  // Raw per-pixel overlaps; held low during reset so downstream never sees garbage.
  assign crash_me   = ~rst & bus.disp_i & bus.me_alpha_i & (|bus.enemy_alpha_i);
  assign crash_eb   = {N_ENEMY{~rst & bus.disp_i & bus.bullet_alpha_i}} & bus.enemy_alpha_i;
  assign pause_rise = bus.pause_i & ~pause_q;
  assign active     = (state == ST_RUN) || (state == ST_RESPAWN);

  // Saturating score increment from the number of channels destroyed this frame.
  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < int'(N_ENEMY); i++) kill_cnt = kill_cnt + POP_W'(kill[i]);
    score_sum = SUM_W'(score) + SUM_W'(kill_cnt);
    score_nx  = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state      <= ST_PRERUN;
      resume     <= ST_RUN;
      lives      <= 3'(LIVES);
      score      <= '0;
      bomb       <= '0;
      kill       <= '0;
      hit_me     <= 1'b0;
      pause_q    <= 1'b0;
      over_armed <= 1'b0;
      inv_cnt    <= '0;
    end else begin
      pause_q <= bus.pause_i;
      bomb    <= '0;
      if (bus.frame_i) begin
        // Frame boundary: settle accumulated flags; overrides any same-cycle control request.
        kill   <= '0;
        hit_me <= 1'b0;
        if (active) begin
          bomb  <= kill;
          score <= score_nx;
        end
        if (state == ST_RUN && hit_me) begin
          lives <= lives - 3'd1;
          if (lives == 3'd1) begin
            state      <= ST_OVER;
            over_armed <= 1'b0;
          end else begin
            state   <= ST_RESPAWN;
            inv_cnt <= INV_W'(INVULN_FRM);
          end
        end else if (state == ST_RESPAWN) begin
          inv_cnt <= inv_cnt - INV_W'(1);
          if (inv_cnt == INV_W'(1)) state <= ST_RUN;
        end
      end else begin
        if (state == ST_RUN && crash_me) hit_me <= 1'b1;
        if (active) kill <= kill | crash_eb;
        case (state)
          ST_PRERUN: if (bus.gamestart_i) begin
            state <= ST_RUN;
            lives <= 3'(LIVES);
            score <= '0;
          end
          // Restart only after the start request has been seen released once.
          ST_OVER: begin
            if (!bus.gamestart_i) over_armed <= 1'b1;
            else if (over_armed) state <= ST_PRERUN;
          end
          ST_RUN, ST_RESPAWN: if (pause_rise) begin
            resume <= state;
            state  <= ST_PAUSE;
          end
          ST_PAUSE: if (pause_rise) state <= resume;
          default: ;
        endcase
      end
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] hiscore;
  logic               enter_over;

  assign enter_over = bus.frame_i && (state == ST_RUN) && hit_me && (lives == 3'd1);

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) hiscore <= '0;
    else if (enter_over && (score_nx > hiscore)) hiscore <= score_nx;
  end

  assign bus.hiscore_o = hiscore;
`else
  assign bus.hiscore_o = '0;
`endif

  assign bus.game_status_o        = state;
  assign bus.crash_me_enemy_o     = crash_me;
  assign bus.crash_enemy_bullet_o = crash_eb;
  assign bus.bomb_o               = bomb;
  assign bus.lives_o              = lives;
  assign bus.score_o              = score;
endmodule

// File: tb/tb_game_ctrl_mc.sv
// Directed vector bench for game_ctrl_mc: a 16-bit-score and a 4-bit-score instance share stimulus.
module tb_game_ctrl_mc;
  logic clk = 1'b0;
  logic rst;
  logic disp, me, bullet, frame, gs, pause;
  logic [3:0] enemy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_ctrl_mc_if #(.N_ENEMY(4), .SCORE_W(16)) bus16 ();
  game_ctrl_mc_if #(.N_ENEMY(4), .SCORE_W(4))  bus4 ();

  assign bus16.frame_i = frame;  assign bus4.frame_i = frame;
  assign bus16.disp_i = disp;    assign bus4.disp_i = disp;
  assign bus16.me_alpha_i = me;  assign bus4.me_alpha_i = me;
  assign bus16.bullet_alpha_i = bullet; assign bus4.bullet_alpha_i = bullet;
  assign bus16.enemy_alpha_i = enemy;   assign bus4.enemy_alpha_i = enemy;
  assign bus16.gamestart_i = gs; assign bus4.gamestart_i = gs;
  assign bus16.pause_i = pause;  assign bus4.pause_i = pause;

  game_ctrl_mc #(.N_ENEMY(4), .LIVES(3), .INVULN_FRM(60), .SCORE_W(16)) dut16 (
    .clk_vga(clk), .rst(rst), .bus(bus16));
  game_ctrl_mc #(.N_ENEMY(4), .LIVES(3), .INVULN_FRM(60), .SCORE_W(4)) dut4 (
    .clk_vga(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic       disp, me, bullet;
    logic [3:0] enemy;
    logic       frame, gs, pause;
    logic [2:0] st;
    logic       cme;
    logic [3:0] ceb, bomb;
    logic [2:0] lives;
    logic [15:0] score;
  } vec_t;

  function automatic vec_t mk(logic d, logic m, logic b, logic [3:0] e, logic f, logic g,
                              logic p, logic [2:0] st, logic cme, logic [3:0] ceb,
                              logic [3:0] bomb, logic [2:0] lv, logic [15:0] sc);
    vec_t v;
    v.disp = d; v.me = m; v.bullet = b; v.enemy = e; v.frame = f; v.gs = g; v.pause = p;
    v.st = st; v.cme = cme; v.ceb = ceb; v.bomb = bomb; v.lives = lv; v.score = sc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic d, input logic m, input logic b, input logic [3:0] e,
                     input logic f, input logic g, input logic p);
    disp = d; me = m; bullet = b; enemy = e; frame = f; gs = g; pause = p;
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_both(input string nm, input logic [2:0] st, input logic [2:0] lv);
    chk({nm, "_status16"}, 32'(bus16.game_status_o), 32'(st));
    chk({nm, "_status4"}, 32'(bus4.game_status_o), 32'(st));
    chk({nm, "_lives16"}, 32'(bus16.lives_o), 32'(lv));
  endtask

  vec_t tbl[13];
  logic [15:0] exp_hi16, exp_hi4;

  initial begin
    // Columns: disp me bullet enemy frame gs pause | status cme ceb bomb lives score
    tbl[0]  = mk(0,0,0,4'h0,0,0,0, 3'b010,0,4'h0,4'h0,3,0);
    tbl[1]  = mk(0,0,0,4'h0,0,1,0, 3'b001,0,4'h0,4'h0,3,0);
    tbl[2]  = mk(1,0,1,4'h5,0,0,0, 3'b001,0,4'h5,4'h0,3,0);
    tbl[3]  = mk(0,0,0,4'h0,0,0,0, 3'b001,0,4'h0,4'h0,3,0);
    tbl[4]  = mk(0,0,0,4'h0,1,0,0, 3'b001,0,4'h0,4'h5,3,2);
    tbl[5]  = mk(0,0,0,4'h0,0,0,0, 3'b001,0,4'h0,4'h0,3,2);
    tbl[6]  = mk(1,1,0,4'h8,0,0,0, 3'b001,1,4'h0,4'h0,3,2);
    tbl[7]  = mk(1,1,1,4'h8,0,0,0, 3'b001,1,4'h8,4'h0,3,2);
    tbl[8]  = mk(0,0,0,4'h0,1,0,0, 3'b101,0,4'h0,4'h8,2,3);
    tbl[9]  = mk(0,0,0,4'h0,0,0,0, 3'b101,0,4'h0,4'h0,2,3);
    tbl[10] = mk(1,1,0,4'h1,0,0,0, 3'b101,1,4'h0,4'h0,2,3);
    tbl[11] = mk(0,1,1,4'h1,0,0,0, 3'b101,0,4'h0,4'h0,2,3);
    tbl[12] = mk(0,0,0,4'h0,1,0,0, 3'b101,0,4'h0,4'h0,2,3);

    // Reset with every alpha asserted: crash outputs must stay low.
    rst = 1'b1; disp = 1'b1; me = 1'b1; bullet = 1'b1; enemy = 4'hf;
    frame = 1'b0; gs = 1'b0; pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_crash_me", 32'(bus16.crash_me_enemy_o), 32'd0);
    chk("rst_crash_eb", 32'(bus16.crash_enemy_bullet_o), 32'd0);
    chk("rst_bomb", 32'(bus16.bomb_o), 32'd0);
    chk("rst_hiscore", 32'(bus16.hiscore_o), 32'd0);
    chk_both("rst", 3'b010, 3'd3);
    rst = 1'b0;
    disp = 1'b0; me = 1'b0; bullet = 1'b0; enemy = 4'h0;

    for (int i = 0; i < 13; i++) begin
      disp = tbl[i].disp; me = tbl[i].me; bullet = tbl[i].bullet; enemy = tbl[i].enemy;
      frame = tbl[i].frame; gs = tbl[i].gs; pause = tbl[i].pause;
      #1;
      chk($sformatf("v%0d_crash_me", i), 32'(bus16.crash_me_enemy_o), 32'(tbl[i].cme));
      chk($sformatf("v%0d_crash_eb", i), 32'(bus16.crash_enemy_bullet_o), 32'(tbl[i].ceb));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_status", i), 32'(bus16.game_status_o), 32'(tbl[i].st));
      chk($sformatf("v%0d_bomb", i), 32'(bus16.bomb_o), 32'(tbl[i].bomb));
      chk($sformatf("v%0d_lives", i), 32'(bus16.lives_o), 32'(tbl[i].lives));
      chk($sformatf("v%0d_score", i), 32'(bus16.score_o), 32'(tbl[i].score));
      chk($sformatf("v%0d_score4", i), 32'(bus4.score_o), 32'(tbl[i].score[3:0]));
    end

    // Pause from RESPAWN (59 invulnerable frames left), idle frames, kill attempt ignored.
    cyc(0,0,0,4'h0,0,0,1); chk_both("pause_in", 3'b000, 3'd2);
    cyc(0,0,0,4'h0,0,0,0);
    cyc(1,0,1,4'hf,0,0,0);
    frames(1);
    chk("pause_bomb", 32'(bus16.bomb_o), 32'd0);
    chk("pause_score", 32'(bus16.score_o), 32'd3);
    frames(9);
    chk_both("pause_hold", 3'b000, 3'd2);
    cyc(0,0,0,4'h0,0,0,1); chk_both("pause_out", 3'b101, 3'd2);
    cyc(0,0,0,4'h0,0,0,0);
    frames(58); chk_both("inv_58", 3'b101, 3'd2);
    frames(1);  chk_both("inv_done", 3'b001, 3'd2);

    // Five all-channel kill frames: 16-bit score climbs, 4-bit score saturates at 15.
    for (int k = 1; k <= 5; k++) begin
      cyc(1,0,1,4'hf,0,0,0);
      frames(1);
      chk($sformatf("kill%0d_bomb", k), 32'(bus16.bomb_o), 32'hf);
      chk($sformatf("kill%0d_score16", k), 32'(bus16.score_o), 32'(3 + 4 * k));
      chk($sformatf("kill%0d_score4", k), 32'(bus4.score_o),
          32'((3 + 4 * k) > 15 ? 15 : 3 + 4 * k));
    end
    cyc(0,0,0,4'h0,0,0,0);
    chk("bomb_one_cycle", 32'(bus16.bomb_o), 32'd0);

    // Two more hits: second-to-last life, then game over with start held through the frame.
    cyc(1,1,0,4'h1,0,0,0);
    frames(1); chk_both("hit2", 3'b101, 3'd1);
    frames(60); chk_both("hit2_inv", 3'b001, 3'd1);
    cyc(1,1,0,4'h2,0,0,0);
    cyc(0,0,0,4'h0,1,1,0); chk_both("over", 3'b011, 3'd0);
    chk("over_score16", 32'(bus16.score_o), 32'd23);
`ifdef GAME_CTRL_HISCORE_EN
    exp_hi16 = 16'd23; exp_hi4 = 16'd15;
`else
    exp_hi16 = 16'd0;  exp_hi4 = 16'd0;
`endif
    chk("over_hiscore16", 32'(bus16.hiscore_o), 32'(exp_hi16));
    chk("over_hiscore4", 32'(bus4.hiscore_o), 32'(exp_hi4));
    cyc(0,0,0,4'h0,0,1,0); chk_both("over_held_start", 3'b011, 3'd0);
    cyc(0,0,0,4'h0,0,0,0); chk_both("over_release", 3'b011, 3'd0);
    cyc(0,0,0,4'h0,0,1,0); chk_both("over_restart", 3'b010, 3'd0);
    cyc(0,0,0,4'h0,0,1,0); chk_both("rerun", 3'b001, 3'd3);
    chk("rerun_score", 32'(bus16.score_o), 32'd0);
    chk("rerun_hiscore16", 32'(bus16.hiscore_o), 32'(exp_hi16));
    chk("rerun_hiscore4", 32'(bus4.hiscore_o), 32'(exp_hi4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
